// File: rtl/imm_extend_pipe.sv
// Registered immediate-extension stage: extends an IN_W-bit immediate to OUT_W bits
// (sign, zero, upper or word-offset) behind a valid/ready handshake with a 2-entry skid.
module imm_extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_imm,
    output logic             out_neg,
    output logic [15:0]      xfer_count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // Mode 3 shifts the sign-extended value, so its top two bits fall off the end.
    function automatic logic [OUT_W-1:0] extend_imm(input logic [IN_W-1:0] imm,
                                                    input logic [1:0]      mode);
        logic [OUT_W-1:0] sext;
        sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
        case (mode)
            2'd0:    extend_imm = sext;
            2'd1:    extend_imm = {{(OUT_W-IN_W){1'b0}}, imm};
            2'd2:    extend_imm = {imm, {(OUT_W-IN_W){1'b0}}};
            2'd3:    extend_imm = sext << 2'd2;
            default: extend_imm = '0;
        endcase
    endfunction

    state_t           state_r;
    logic [OUT_W-1:0] skid_r;
    logic [OUT_W-1:0] ext_s;
    logic             in_xfer_s;
    logic             out_xfer_s;

    // Extension result and handshake qualifiers for this cycle.
    always_comb begin
        ext_s      = extend_imm(in_imm, in_mode);
        in_xfer_s  = in_valid & in_ready;
        out_xfer_s = out_valid & out_ready;
    end

    // Two-entry storage FSM; in_ready is registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_EMPTY;
            out_valid  <= 1'b0;
            in_ready   <= 1'b1;
            out_imm    <= '0;
            out_neg    <= 1'b0;
            skid_r     <= '0;
            xfer_count <= 16'd0;
        end else begin
            if (out_xfer_s) begin
                xfer_count <= xfer_count + 16'd1;
            end
            case (state_r)
                ST_EMPTY: begin
                    if (in_xfer_s) begin
                        out_imm   <= ext_s;
                        out_neg   <= ext_s[OUT_W-1];
                        out_valid <= 1'b1;
                        state_r   <= ST_ONE;
                    end
                    in_ready <= 1'b1;
                end
                ST_ONE: begin
                    if (in_xfer_s && out_xfer_s) begin
                        out_imm <= ext_s;
                        out_neg <= ext_s[OUT_W-1];
                    end else if (in_xfer_s) begin
                        skid_r   <= ext_s;
                        state_r  <= ST_FULL;
                        in_ready <= 1'b0;
                    end else if (out_xfer_s) begin
                        out_valid <= 1'b0;
                        state_r   <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_xfer_s) begin
                        out_imm  <= skid_r;
                        out_neg  <= skid_r[OUT_W-1];
                        state_r  <= ST_ONE;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to a clean empty stage.
                    state_r   <= ST_EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
